// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register of the 5-stage RV32I core.
// Holds the decoded instruction for one cycle between decode and execute,
// detects load-use hazards against the held instruction, and supports
// bubble insertion on branch/jump flush and freezing on a downstream hold.
// Optional build macro: ID_EX_PERF_EN adds saturating bubble/flush counters.
// Without it the counter outputs are tied to zero.

module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              valid_i,
    input  logic [23:0]       ctrl_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              valid_o,
    output logic [23:0]       ctrl_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [XLEN-1:0]   pc_o,
    output logic              stall_o,
    output logic [PERF_W-1:0] bubble_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    // WDSel value selecting data memory as the write-back source (a load).
    localparam logic [1:0] WDSEL_MEM = 2'b01;

    // Everything the execute stage sees, kept together so a bubble is a
    // single all-zero assignment (NPCOp=0 is PLUS4, RegWrite/MemWrite=0).
    typedef struct packed {
        logic              valid;
        logic [23:0]       ctrl;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } stage_t;

    // One action per clock edge; reset is handled separately in the flop.
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_CAPTURE
    } action_e;

    stage_t  stage_d, stage_q;
    action_e action;
    logic    ex_is_load;
    logic    rs1_hit, rs2_hit;
    logic    load_use;

    // Hazard detection against the instruction currently held for execute.
    // A bubble has valid=0 and ctrl=0, so it can never look like a load.
    assign ex_is_load = stage_q.valid && (stage_q.ctrl[4:3] == WDSEL_MEM)
                        && (stage_q.rd != '0);
    assign rs1_hit    = rs1_used_i && (rs1_i == stage_q.rd);
    assign rs2_hit    = rs2_used_i && (rs2_i == stage_q.rd);
    assign load_use   = ex_is_load && (rs1_hit || rs2_hit) && valid_i;

    // Hold and flush both mask the stall: the decode instruction is either
    // frozen anyway or about to be killed.
    assign stall_o = rstn && load_use && !flush_i && !hold_i;

    // Select the single action taken at the next edge, highest priority first.
    always_comb begin
        action = ACT_CAPTURE;
        if (hold_i) begin
            action = ACT_HOLD;
        end else if (flush_i) begin
            action = ACT_FLUSH;
        end else if (load_use) begin
            action = ACT_BUBBLE;
        end
    end

    // Next-state of the stage register for the chosen action.
    always_comb begin
        // NOTE: default assignment first so every path drives stage_d and no latch is inferred.
        stage_d = stage_q;
        unique case (action)
            ACT_FLUSH, ACT_BUBBLE: begin
                stage_d = '0;
            end
            ACT_CAPTURE: begin
                stage_d.valid    = valid_i;
                stage_d.ctrl     = valid_i ? ctrl_i : '0;
                stage_d.rs1      = rs1_i;
                stage_d.rs2      = rs2_i;
                stage_d.rd       = rd_i;
                stage_d.rs1_data = rs1_data_i;
                stage_d.rs2_data = rs2_data_i;
                stage_d.imm      = imm_i;
                stage_d.pc       = pc_i;
            end
            default: begin
                stage_d = stage_q;
            end
        endcase
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so all flops update together at the edge.
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_o    = stage_q.valid;
    assign ctrl_o     = stage_q.ctrl;
    assign rs1_o      = stage_q.rs1;
    assign rs2_o      = stage_q.rs2;
    assign rd_o       = stage_q.rd;
    assign rs1_data_o = stage_q.rs1_data;
    assign rs2_data_o = stage_q.rs2_data;
    assign imm_o      = stage_q.imm;
    assign pc_o       = stage_q.pc;

`ifdef ID_EX_PERF_EN
    logic [PERF_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [PERF_W-1:0] flush_cnt_d, flush_cnt_q;

    // Saturating event counters; a hold edge selects neither event so they freeze.
    // A flush only counts when it actually killed something.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if ((action == ACT_BUBBLE) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + PERF_W'(1);
        end
        if ((action == ACT_FLUSH) && (stage_q.valid || valid_i)
            && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`else
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg. A reference model predicts the
// stage contents after every edge and the stall for the current cycle; the
// predictions are queued when stimulus is applied and compared by a monitor
// when the DUT produces them. Scenario tasks add their own targeted checks.

module tb_id_ex_pipe_reg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int PERF_W = 4;
`ifdef ID_EX_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    localparam logic [23:0] LW_CTRL   = 24'h80_000A;  // RegWrite, WDSel=01, DMType=word
    localparam logic [23:0] ADD_CTRL  = 24'h84_2210;  // WDSel=10
    localparam logic [23:0] ADDI_CTRL = 24'hC1_0AB0;

    logic              clk;
    logic              rstn;
    logic              valid_i;
    logic [23:0]       ctrl_i;
    logic              rs1_used_i, rs2_used_i;
    logic [REG_AW-1:0] rs1_i, rs2_i, rd_i;
    logic [XLEN-1:0]   rs1_data_i, rs2_data_i, imm_i, pc_i;
    logic              flush_i, hold_i;
    logic              valid_o;
    logic [23:0]       ctrl_o;
    logic [REG_AW-1:0] rs1_o, rs2_o, rd_o;
    logic [XLEN-1:0]   rs1_data_o, rs2_data_o, imm_o, pc_o;
    logic              stall_o;
    logic [PERF_W-1:0] bubble_cnt_o, flush_cnt_o;

    id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .PERF_W(PERF_W)) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .ctrl_i(ctrl_i),
        .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .valid_o(valid_o), .ctrl_o(ctrl_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o), .pc_o(pc_o),
        .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // Clock starts high so the first falling edge (drive point) precedes the first rising edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic              stall;
        logic              valid;
        logic [23:0]       ctrl;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [XLEN-1:0]   d1, d2, imm, pc;
        logic [PERF_W-1:0] bub, flc;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Zero the execute-visible fields, keeping the counters.
    function automatic exp_t kill(input exp_t e);
        exp_t r;
        r = '0;
        r.bub = e.bub;
        r.flc = e.flc;
        return r;
    endfunction

    // Predict this cycle's stall and the post-edge state, push, advance one clock.
    task automatic tick();
        exp_t nx;
        logic lu;
        lu = m.valid && (m.ctrl[4:3] == 2'b01) && (m.rd != '0) && valid_i &&
             ((rs1_used_i && (rs1_i == m.rd)) || (rs2_used_i && (rs2_i == m.rd)));
        nx = m;
        nx.stall = rstn && lu && !flush_i && !hold_i;
        if (!rstn) begin
            nx = '0;
        end else if (hold_i) begin
            nx.valid = m.valid;
        end else if (flush_i) begin
            nx = kill(m);
            if ((m.valid || valid_i) && (m.flc != '1)) nx.flc = m.flc + 1'b1;
        end else if (lu) begin
            nx = kill(m);
            if (m.bub != '1) nx.bub = m.bub + 1'b1;
        end else begin
            nx.valid = valid_i;
            nx.ctrl  = valid_i ? ctrl_i : 24'h0;
            nx.rs1   = rs1_i;
            nx.rs2   = rs2_i;
            nx.rd    = rd_i;
            nx.d1    = rs1_data_i;
            nx.d2    = rs2_data_i;
            nx.imm   = imm_i;
            nx.pc    = pc_i;
        end
        nx.stall = rstn && lu && !flush_i && !hold_i;
        sb.push_back(nx);
        m = nx;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitor: stall mid-low-phase, registered state 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                n_checks++;
                if (stall_o !== sb[0].stall) begin
                    n_fail++;
                    $display("FAIL sb_stall t=%0t got %b want %b", $time, stall_o, sb[0].stall);
                end
            end
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({valid_o, ctrl_o, rs1_o, rs2_o, rd_o, rs1_data_o, rs2_data_o, imm_o, pc_o} !==
                    {e.valid, e.ctrl, e.rs1, e.rs2, e.rd, e.d1, e.d2, e.imm, e.pc}) begin
                    n_fail++;
                    $display("FAIL sb_stage t=%0t got v=%b c=%h rs=%0d/%0d rd=%0d d=%h/%h imm=%h pc=%h want v=%b c=%h rs=%0d/%0d rd=%0d d=%h/%h imm=%h pc=%h",
                             $time, valid_o, ctrl_o, rs1_o, rs2_o, rd_o, rs1_data_o, rs2_data_o, imm_o, pc_o,
                             e.valid, e.ctrl, e.rs1, e.rs2, e.rd, e.d1, e.d2, e.imm, e.pc);
                end
                n_checks++;
                if ({bubble_cnt_o, flush_cnt_o} !== (PERF_ON ? {e.bub, e.flc} : 8'h0)) begin
                    n_fail++;
                    $display("FAIL sb_counters t=%0t got bub=%h flush=%h want bub=%h flush=%h",
                             $time, bubble_cnt_o, flush_cnt_o,
                             PERF_ON ? e.bub : 4'h0, PERF_ON ? e.flc : 4'h0);
                end
            end
        end
    end

    task automatic idle();
        rstn = 1'b1; valid_i = 1'b0; ctrl_i = '0; rs1_used_i = 1'b0; rs2_used_i = 1'b0;
        rs1_i = '0; rs2_i = '0; rd_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        imm_i = '0; pc_i = '0; flush_i = 1'b0; hold_i = 1'b0;
    endtask

    task automatic instr(input logic [23:0] c, input logic [4:0] rd, input logic [4:0] r1,
                         input logic u1, input logic [4:0] r2, input logic u2,
                         input logic [31:0] pc);
        valid_i = 1'b1; ctrl_i = c; rd_i = rd; rs1_i = r1; rs1_used_i = u1;
        rs2_i = r2; rs2_used_i = u2; pc_i = pc;
        rs1_data_i = {27'h0, r1} ^ 32'hA5A5_0000; rs2_data_i = pc ^ 32'h0F0F_00FF;
        imm_i = pc + 32'd12;
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0; valid_i = 1'b1; ctrl_i = ADDI_CTRL; pc_i = 32'h1234;
        tick();
        idle();
        instr(LW_CTRL, 5'd6, 5'd2, 1'b1, 5'd0, 1'b0, 32'h20);
        tick();
        instr(ADD_CTRL, 5'd7, 5'd6, 1'b1, 5'd0, 1'b0, 32'h24);
        rstn = 1'b0;
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_stall got %b want 0", stall_o);
        end
        tick();
        n_checks++;
        if ({valid_o, ctrl_o, pc_o} !== 57'h0) begin
            n_fail++; $display("FAIL reset_midstream got v=%b c=%h pc=%h want all 0", valid_o, ctrl_o, pc_o);
        end
        idle();
    endtask

    task automatic test_plain_flow();
        instr(ADDI_CTRL, 5'd5, 5'd1, 1'b1, 5'd0, 1'b0, 32'h40);
        tick();
        idle();
        #1;
        n_checks++;
        if ({valid_o, ctrl_o, pc_o, rd_o, stall_o} !== {1'b1, ADDI_CTRL, 32'h40, 5'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL plain_flow got v=%b c=%h pc=%h rd=%0d st=%b want v=1 c=%h pc=40 rd=5 st=0",
                     valid_o, ctrl_o, pc_o, rd_o, stall_o, ADDI_CTRL);
        end
        tick();
    endtask

    task automatic test_load_use();
        instr(LW_CTRL, 5'd6, 5'd1, 1'b1, 5'd0, 1'b0, 32'h100);
        tick();
        instr(ADD_CTRL, 5'd7, 5'd6, 1'b1, 5'd3, 1'b1, 32'h104);
        #1;
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall got %b want 1", stall_o);
        end
        tick();
        n_checks++;
        if ({valid_o, ctrl_o} !== 25'h0) begin
            n_fail++; $display("FAIL load_use_bubble got v=%b c=%h want 0/0", valid_o, ctrl_o);
        end
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release got %b want 0", stall_o);
        end
        tick();
        n_checks++;
        if ({valid_o, ctrl_o, rd_o, pc_o} !== {1'b1, ADD_CTRL, 5'd7, 32'h104}) begin
            n_fail++; $display("FAIL load_use_capture got v=%b c=%h rd=%0d pc=%h want v=1 c=%h rd=7 pc=104",
                               valid_o, ctrl_o, rd_o, pc_o, ADD_CTRL);
        end
        n_checks++;
        if (bubble_cnt_o !== (PERF_ON ? 4'd1 : 4'd0)) begin
            n_fail++; $display("FAIL load_use_bubble_cnt got %0d want %0d", bubble_cnt_o, PERF_ON ? 1 : 0);
        end
        idle();
    endtask

    task automatic test_no_false_stall();
        logic [4:0] r1 [3] = '{5'd0, 5'd3, 5'd6};
        logic [4:0] r2 [3] = '{5'd0, 5'd6, 5'd0};
        logic       u1 [3] = '{1'b1, 1'b1, 1'b1};
        logic       v  [3] = '{1'b1, 1'b1, 1'b0};
        logic [4:0] ld [3] = '{5'd0, 5'd6, 5'd6};
        for (int i = 0; i < 3; i++) begin
            instr(LW_CTRL, ld[i], 5'd1, 1'b1, 5'd0, 1'b0, 32'h200 + 32'(i * 8));
            tick();
            instr(ADD_CTRL, 5'd9, r1[i], u1[i], r2[i], 1'b0, 32'h204 + 32'(i * 8));
            valid_i = v[i];
            #1;
            n_checks++;
            if (stall_o !== 1'b0) begin
                n_fail++; $display("FAIL no_false_stall case=%0d got %b want 0", i, stall_o);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush_hold();
        instr(LW_CTRL, 5'd6, 5'd1, 1'b1, 5'd0, 1'b0, 32'h300);
        tick();
        instr(ADD_CTRL, 5'd8, 5'd6, 1'b1, 5'd0, 1'b0, 32'h304);
        hold_i = 1'b1; flush_i = 1'b1;
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL hold_flush_stall got %b want 0", stall_o);
        end
        tick();
        n_checks++;
        if ({valid_o, ctrl_o, rd_o, pc_o} !== {1'b1, LW_CTRL, 5'd6, 32'h300}) begin
            n_fail++; $display("FAIL hold_frozen got v=%b c=%h rd=%0d pc=%h want v=1 c=%h rd=6 pc=300",
                               valid_o, ctrl_o, rd_o, pc_o, LW_CTRL);
        end
        hold_i = 1'b0;
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_masks_stall got %b want 0", stall_o);
        end
        tick();
        n_checks++;
        if ({valid_o, ctrl_o, rd_o, pc_o} !== 62'h0) begin
            n_fail++; $display("FAIL flush_bubble got v=%b c=%h rd=%0d pc=%h want all 0", valid_o, ctrl_o, rd_o, pc_o);
        end
        valid_i = 1'b0;
        tick();
        n_checks++;
        if (flush_cnt_o !== (PERF_ON ? 4'd1 : 4'd0)) begin
            n_fail++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt_o, PERF_ON ? 1 : 0);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        instr(LW_CTRL, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h400);
        tick();
        for (int k = 2; k <= 4; k++) begin
            instr(LW_CTRL, 5'(k), 5'(k - 1), 1'b1, 5'd0, 1'b0, 32'h400 + 32'(k * 4));
            for (int c = 0; c < 2; c++) begin
                #1;
                if (stall_o === 1'b1) stalls++;
                tick();
            end
        end
        n_checks++;
        if (stalls != 3) begin
            n_fail++; $display("FAIL back_to_back_stalls got %0d want 3", stalls);
        end
        n_checks++;
        if ({valid_o, rd_o} !== {1'b1, 5'd4}) begin
            n_fail++; $display("FAIL back_to_back_last got v=%b rd=%0d want v=1 rd=4", valid_o, rd_o);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            rstn       = ($urandom_range(0, 29) != 0);
            valid_i    = ($urandom_range(0, 3) != 0);
            ctrl_i     = 24'($urandom);
            if ($urandom_range(0, 1) == 1) ctrl_i[4:3] = 2'b01;
            rs1_used_i = 1'($urandom);
            rs2_used_i = 1'($urandom);
            rs1_i      = 5'($urandom_range(0, 3));
            rs2_i      = 5'($urandom_range(0, 3));
            rd_i       = 5'($urandom_range(0, 3));
            rs1_data_i = $urandom; rs2_data_i = $urandom;
            imm_i      = $urandom; pc_i = $urandom;
            flush_i    = ($urandom_range(0, 7) == 0);
            hold_i     = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
    endtask

    task automatic test_saturation();
        rstn = 1'b0;
        tick();
        idle();
        instr(LW_CTRL, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 32'h500);
        tick();
        for (int i = 0; i < 28; i++) tick();
        n_checks++;
        if (bubble_cnt_o !== (PERF_ON ? 4'hE : 4'h0)) begin
            n_fail++; $display("FAIL sat_14 got %h want %h", bubble_cnt_o, PERF_ON ? 4'hE : 4'h0);
        end
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (bubble_cnt_o !== (PERF_ON ? 4'hF : 4'h0)) begin
            n_fail++; $display("FAIL sat_17 got %h want %h", bubble_cnt_o, PERF_ON ? 4'hF : 4'h0);
        end
        idle();
        tick();
    endtask

    initial begin
        m = '0;
        idle();
        @(negedge clk);
        test_reset();
        test_plain_flow();
        test_load_use();
        test_no_false_stall();
        test_flush_hold();
        test_back_to_back();
        test_random();
        test_saturation();
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
